ft601_tx_packetizer: RTL and testbench

Upstream feeder for one FT601 multi-channel FIFO write channel (the wr_ch_* port group of ft601_mcfifo_if). It accepts a 32-bit word stream from PL logic with valid/ready handshake and writes it into the channel FIFO. It frames the stream into packets of at most MAX_PACKET_SIZE bytes and asserts push when a packet is full, when the source marks the last word, or when the stream goes idle. One instance per channel, all in the system clk domain.

---
 rtl/ft601_pkg.sv | 37 +++
 rtl/ft601_idle_timer.sv | 46 ++++
 rtl/ft601_tx_packetizer.sv | 216 +++++++++++++++++++++
 tb/tb_ft601_tx_packetizer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ft601_pkg.sv
// ---------------------------------------------------------------------------
// ft601_pkg
// Shared constants and types for the FT601 multi-channel FIFO packet blocks
// (tx packetizer, rx depacketizer).
//   FT601_WORD_BYTES : bytes per FIFO word
//   FT601_HDR_MAGIC  : first byte of the optional packet header word
//   pkt_state_t      : packetizer state encoding
//   ft601_hdr_t      : header word layout {magic, chan, seq}
// ---------------------------------------------------------------------------
package ft601_pkg;

    localparam int         FT601_WORD_BYTES = 4;
    localparam logic [7:0] FT601_HDR_MAGIC  = 8'hA5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        FILL = 2'd2,
        PUSH = 2'd3
    } pkt_state_t;

    typedef struct packed {
        logic [7:0]  magic;
        logic [7:0]  chan;
        logic [15:0] seq;
    } ft601_hdr_t;

    // Assemble a header word from channel number and sequence number.
    function automatic ft601_hdr_t ft601_make_hdr(input logic [7:0] chan, input logic [15:0] seq);
        ft601_hdr_t h;
        h.magic = FT601_HDR_MAGIC;
        h.chan  = chan;
        h.seq   = seq;
        return h;
    endfunction

endpackage

// File: rtl/ft601_idle_timer.sv
// ---------------------------------------------------------------------------
// ft601_idle_timer
// Counts idle cycles and flags the cycle in which the count reaches
// TIMEOUT_CYCLES-1 while still enabled. TIMEOUT_CYCLES = 0 disables the
// timeout pulse entirely.
// Ports:
//   clk      in  system clock
//   reset_n  in  asynchronous active-low reset
//   clear    in  restart counting from zero (has priority over enable)
//   enable   in  count this cycle as idle
//   timeout  out combinational pulse: this idle cycle is the last one allowed
// ---------------------------------------------------------------------------
module ft601_idle_timer #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam int          CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int          LAST_I   = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;
    localparam logic [CW-1:0] LAST_W = LAST_I[CW-1:0];
    localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
    localparam bit          TIMER_ON = (TIMEOUT_CYCLES != 0);

    logic [CW-1:0] idle_r;

    // Idle cycle counter: cleared on request, otherwise advances while enabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_r <= '0;
        end else if (clear) begin
            idle_r <= '0;
        end else if (enable) begin
            idle_r <= idle_r + CNT_ONE;
        end else begin
            idle_r <= idle_r;
        end
    end

    assign timeout = TIMER_ON && enable && !clear && (idle_r == LAST_W);

endmodule

// File: rtl/ft601_tx_packetizer.sv
// ---------------------------------------------------------------------------
// ft601_tx_packetizer
// Feeds one FT601 write channel from a 32-bit valid/ready stream. Words are
// written into the channel FIFO (wr_en one cycle after each transfer) and
// committed with a one-cycle wr_push when the packet is full, when the source
// marks in_last, or when a partial packet has been idle for TIMEOUT_CYCLES.
//
// Optional build macro FT601_PKT_HEADER_EN: each packet starts with a header
// word {8'hA5, CHANNEL_NUM[7:0], pkt_count[15:0]} that counts toward the
// packet word budget.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   in_data/in_be           stream word and its byte enables
//   in_valid/in_ready       stream handshake (in_ready is combinational)
//   in_last                 word closes the current packet
//   wr_data/wr_be/wr_en     FIFO write (registered)
//   wr_push                 one-cycle packet commit (registered)
//   wr_full                 FIFO cannot take a word this cycle
//   wr_has_packet_space     room for a whole packet, checked before each packet
//   pkt_count               packets pushed (wraps)
//   timeout_count           pushes caused by idle timeout (wraps)
// ---------------------------------------------------------------------------
module ft601_tx_packetizer
    import ft601_pkg::*;
#(
    parameter int MAX_PACKET_SIZE = 1024,
    parameter int TIMEOUT_CYCLES  = 4096,
    parameter int CHANNEL_NUM     = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] in_data,
    input  logic [3:0]  in_be,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [31:0] wr_data,
    output logic [3:0]  wr_be,
    output logic        wr_en,
    output logic        wr_push,
    input  logic        wr_full,
    input  logic        wr_has_packet_space,
    output logic [15:0] pkt_count,
    output logic [15:0] timeout_count
);

    localparam int              WORDS    = MAX_PACKET_SIZE / FT601_WORD_BYTES;
    localparam int              WCW      = $clog2(WORDS + 1);
    localparam logic [WCW-1:0]  WORDS_W  = WORDS[WCW-1:0];
    localparam logic [WCW-1:0]  WCNT_ONE = WCW'(1'b1);
    localparam logic [7:0]      CHAN_W   = CHANNEL_NUM[7:0];

`ifdef FT601_PKT_HEADER_EN
    localparam pkt_state_t FIRST_ST = HDR;
`else
    localparam pkt_state_t FIRST_ST = FILL;
`endif

    pkt_state_t     state_r, state_s;
    logic [WCW-1:0] wcnt_r, wcnt_s;
    logic [31:0]    wr_data_r;
    logic [3:0]     wr_be_r;
    logic           wr_en_r;
    logic           wr_push_r;
    logic [15:0]    pkt_count_r;
    logic [15:0]    timeout_count_r;

    logic           ready_s;
    logic           xfer_s;
    logic           hdr_write_s;
    logic           to_hit_s;
    logic           timeout_s;
    logic           timer_clear_s;
    logic           timer_en_s;
    ft601_hdr_t     hdr_s;

    assign ready_s  = (state_r == FILL) && !wr_full && (wcnt_r < WORDS_W);
    assign in_ready = ready_s;
    assign xfer_s   = in_valid && ready_s;
    assign hdr_s    = ft601_make_hdr(CHAN_W, pkt_count_r);

    // The idle count only runs for a non-empty packet being filled; any
    // transfer or leaving FILL restarts it. A stall on wr_full still counts.
    assign timer_clear_s = xfer_s || (state_r != FILL);
    assign timer_en_s    = (state_r == FILL) && (wcnt_r != '0) && !xfer_s;

    ft601_idle_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (timer_clear_s),
        .enable  (timer_en_s),
        .timeout (timeout_s)
    );

    // Next-state and word-count logic of the packet framing FSM.
    always_comb begin
        state_s     = state_r;
        wcnt_s      = wcnt_r;
        hdr_write_s = 1'b0;
        to_hit_s    = 1'b0;
        case (state_r)
            IDLE: begin
                // Space is checked once per packet so a packet is never split.
                if (in_valid && wr_has_packet_space) begin
                    state_s = FIRST_ST;
                end else begin
                    state_s = IDLE;
                end
            end
`ifdef FT601_PKT_HEADER_EN
            HDR: begin
                if (!wr_full) begin
                    hdr_write_s = 1'b1;
                    wcnt_s      = WCNT_ONE;
                    if (WCNT_ONE == WORDS_W) begin
                        state_s = PUSH;
                    end else begin
                        state_s = FILL;
                    end
                end else begin
                    state_s = HDR;
                end
            end
`endif
            FILL: begin
                if (xfer_s) begin
                    wcnt_s = wcnt_r + WCNT_ONE;
                    // in_last on the final word of a full packet yields one push.
                    if (in_last || ((wcnt_r + WCNT_ONE) == WORDS_W)) begin
                        state_s = PUSH;
                    end else begin
                        state_s = FILL;
                    end
                end else if (timeout_s) begin
                    state_s  = PUSH;
                    to_hit_s = 1'b1;
                end else begin
                    state_s = FILL;
                end
            end
            PUSH: begin
                state_s = IDLE;
                wcnt_s  = '0;
            end
            default: begin
                state_s = IDLE;
                wcnt_s  = '0;
            end
        endcase
    end

    // FSM state and packet word count registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            wcnt_r  <= '0;
        end else begin
            state_r <= state_s;
            wcnt_r  <= wcnt_s;
        end
    end

    // FIFO write port: one registered write per accepted word or header.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_en_r   <= 1'b0;
            wr_data_r <= 32'd0;
            wr_be_r   <= 4'd0;
        end else begin
            wr_en_r <= xfer_s || hdr_write_s;
            if (hdr_write_s) begin
                wr_data_r <= hdr_s;
                wr_be_r   <= 4'hF;
            end else if (xfer_s) begin
                wr_data_r <= in_data;
                wr_be_r   <= in_be;
            end else begin
                wr_data_r <= wr_data_r;
                wr_be_r   <= wr_be_r;
            end
        end
    end

    // Packet commit pulse and statistics counters. The push follows the PUSH
    // state, landing one cycle after the packet's final wr_en.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_push_r       <= 1'b0;
            pkt_count_r     <= 16'd0;
            timeout_count_r <= 16'd0;
        end else begin
            wr_push_r <= (state_r == PUSH);
            if (state_r == PUSH) begin
                pkt_count_r <= pkt_count_r + 16'd1;
            end else begin
                pkt_count_r <= pkt_count_r;
            end
            if (to_hit_s) begin
                timeout_count_r <= timeout_count_r + 16'd1;
            end else begin
                timeout_count_r <= timeout_count_r;
            end
        end
    end

    assign wr_data       = wr_data_r;
    assign wr_be         = wr_be_r;
    assign wr_en         = wr_en_r;
    assign wr_push       = wr_push_r;
    assign pkt_count     = pkt_count_r;
    assign timeout_count = timeout_count_r;

endmodule

// File: tb/tb_ft601_tx_packetizer.sv
// ---------------------------------------------------------------------------
// tb_ft601_tx_packetizer
// Directed bench for ft601_tx_packetizer (MAX_PACKET_SIZE=1024 -> 256 words,
// TIMEOUT_CYCLES=64, CHANNEL_NUM=3). A negedge monitor scoreboards every FIFO
// write against the words the driver handed over and counts pushes; the
// optional header build (FT601_PKT_HEADER_EN) is modelled by the monitor.
// ---------------------------------------------------------------------------
module tb_ft601_tx_packetizer;

    localparam int WORDS = 256;
    localparam int TMO   = 64;
`ifdef FT601_PKT_HEADER_EN
    localparam int HDR_W = 1;
`else
    localparam int HDR_W = 0;
`endif
    localparam int PAY = WORDS - HDR_W;

    logic        clk;
    logic        reset_n;
    logic [31:0] in_data;
    logic [3:0]  in_be;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        wr_en;
    logic        wr_push;
    logic        wr_full;
    logic        wr_has_packet_space;
    logic [15:0] pkt_count;
    logic [15:0] timeout_count;

    ft601_tx_packetizer #(
        .MAX_PACKET_SIZE (1024),
        .TIMEOUT_CYCLES  (TMO),
        .CHANNEL_NUM     (3)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .in_data             (in_data),
        .in_be               (in_be),
        .in_valid            (in_valid),
        .in_last             (in_last),
        .in_ready            (in_ready),
        .wr_data             (wr_data),
        .wr_be               (wr_be),
        .wr_en               (wr_en),
        .wr_push             (wr_push),
        .wr_full             (wr_full),
        .wr_has_packet_space (wr_has_packet_space),
        .pkt_count           (pkt_count),
        .timeout_count       (timeout_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Scoreboard / monitor state.
    logic [35:0] exp_q[$];
    int          cyc = 0;
    int          pay_en = 0;
    int          push_cnt = 0;
    int          last_en_cyc = 0;
    int          push_cyc = 0;
    logic [3:0]  last_be = 4'h0;
    logic [15:0] seq_model = 16'd0;
    logic        hdr_next = 1'b1;
    logic [31:0] seed = 32'h1000_0001;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare each FIFO write with the driver's queue, count pushes.
    initial begin
        logic [35:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                seq_model = 16'd0;
                hdr_next  = 1'b1;
            end else begin
                if (wr_en) begin
`ifdef FT601_PKT_HEADER_EN
                    if (hdr_next) begin
                        chk("hdr_word", wr_data, {8'hA5, 8'h03, seq_model});
                        hdr_next = 1'b0;
                    end else begin
`else
                    begin
`endif
                        if (exp_q.size() == 0) begin
                            chk("unexpected_wr_en", 32'd1, 32'd0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("wr_data", wr_data, e[31:0]);
                            chk("wr_be", {28'd0, wr_be}, {28'd0, e[35:32]});
                        end
                        pay_en++;
                        last_be = wr_be;
                    end
                    last_en_cyc = cyc;
                end
                if (wr_push) begin
                    if (wr_en) chk("push_with_wr_en", 32'd1, 32'd0);
                    push_cnt++;
                    push_cyc  = cyc;
                    seq_model = seq_model + 16'd1;
                    hdr_next  = 1'b1;
                end
            end
        end
    end

    // Drive n words; in_last optionally on the final one; wr_full toggles with
    // period tog (0 = never). first = cycles until the first word was taken.
    task automatic send(input int n, input bit last_fin, input logic [3:0] be_fin,
                        input int tog, output int first);
        int i = 0;
        int k = 0;
        first = -1;
        while (i < n && k < 20000) begin
            @(negedge clk);
            k++;
            if (tog > 0) wr_full = ((k / tog) % 2) == 1;
            in_valid = 1'b1;
            in_data  = seed;
            in_be    = (i == n - 1) ? be_fin : 4'hF;
            in_last  = last_fin && (i == n - 1);
            #1;
            if (in_ready) begin
                exp_q.push_back({in_be, in_data});
                seed = seed + 32'h0101_0003;
                if (first < 0) first = k;
                i++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        wr_full  = 1'b0;
        if (i < n) chk("send_timeout", i, n);
    endtask

    task automatic wait_push(input int target, input int bound);
        int k = 0;
        while (push_cnt < target && k < bound) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (push_cnt < target) chk("push_wait_timeout", push_cnt, target);
    endtask

    typedef struct {
        int         n;
        logic [3:0] be;
        int         exp_push;
    } vec_t;

    vec_t        vecs[5];
    int          p0, e0, first, bad;
    logic [15:0] pkt_exp;

    initial begin
        vecs[0] = '{n: 10,  be: 4'h3, exp_push: (10  + PAY - 1) / PAY};
        vecs[1] = '{n: 1,   be: 4'h1, exp_push: (1   + PAY - 1) / PAY};
        vecs[2] = '{n: 256, be: 4'hC, exp_push: (256 + PAY - 1) / PAY};
        vecs[3] = '{n: 257, be: 4'h7, exp_push: (257 + PAY - 1) / PAY};
        vecs[4] = '{n: 3,   be: 4'h8, exp_push: (3   + PAY - 1) / PAY};

        reset_n = 1'b0; in_data = 32'd0; in_be = 4'd0; in_valid = 1'b0;
        in_last = 1'b0; wr_full = 1'b0; wr_has_packet_space = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_wr_push", {31'd0, wr_push}, 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_pkt_count", {16'd0, pkt_count}, 32'd0);
        chk("rst_timeout_count", {16'd0, timeout_count}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // 600 continuous words: full-packet pushes, then the tail times out.
        send(600, 1'b0, 4'hF, 0, first);
        repeat (2) @(negedge clk);
        #1;
        chk("stream_pushes", push_cnt, 2);
        chk("stream_pkt_count", {16'd0, pkt_count}, 32'd2);
        chk("stream_words", pay_en, 600);
        wait_push(3, 300);
        repeat (2) @(negedge clk);
        #1;
        // Timeout fires in the 64th idle cycle; wr_push follows the PUSH state.
        chk("timeout_latency", push_cyc - last_en_cyc, TMO + 1);
        chk("timeout_count", {16'd0, timeout_count}, 32'd1);
        chk("timeout_pkt_count", {16'd0, pkt_count}, 32'd3);
        pkt_exp = 16'd3;

        // Table of in_last-terminated packets.
        for (int v = 0; v < 5; v++) begin
            p0 = push_cnt;
            e0 = pay_en;
            send(vecs[v].n, 1'b1, vecs[v].be, 0, first);
            wait_push(p0 + vecs[v].exp_push, 800);
            repeat (5) @(negedge clk);
            #1;
            pkt_exp = pkt_exp + 16'(vecs[v].exp_push);
            chk("vec_pushes", push_cnt - p0, vecs[v].exp_push);
            chk("vec_wr_en_count", pay_en - e0, vecs[v].n);
            chk("vec_last_be", {28'd0, last_be}, {28'd0, vecs[v].be});
            chk("vec_push_after_last_en", push_cyc - last_en_cyc, 1);
            chk("vec_pkt_count", {16'd0, pkt_count}, {16'd0, pkt_exp});
            chk("vec_queue_empty", exp_q.size(), 0);
        end
        chk("vec_timeout_count", {16'd0, timeout_count}, 32'd1);

        // No packet space: block must not start or write.
        wr_has_packet_space = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        in_be    = 4'hF;
        bad = 0;
        e0 = pay_en;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            #1;
            if (in_ready || wr_en) bad++;
        end
        chk("space_hold", bad, 0);
        chk("space_hold_no_write", pay_en - e0, 0);
        wr_has_packet_space = 1'b1;
        p0 = push_cnt;
        send(4, 1'b1, 4'hF, 0, first);
        chk("space_release_latency", {31'd0, (first >= 1 && first <= 2)}, 32'd1);
        wait_push(p0 + 1, 200);
        pkt_exp = pkt_exp + 16'd1;

        // wr_full toggling during one full packet: scoreboard checks each word.
        p0 = push_cnt;
        e0 = pay_en;
        send(PAY, 1'b0, 4'hF, 3, first);
        wait_push(p0 + 1, 800);
        repeat (5) @(negedge clk);
        #1;
        pkt_exp = pkt_exp + 16'd1;
        chk("full_toggle_pushes", push_cnt - p0, 1);
        chk("full_toggle_words", pay_en - e0, PAY);
        chk("full_toggle_push_timing", push_cyc - last_en_cyc, 1);
        chk("full_toggle_queue_empty", exp_q.size(), 0);
        chk("full_toggle_pkt_count", {16'd0, pkt_count}, {16'd0, pkt_exp});

        // Reset in the middle of a packet: outputs clear at once, no push.
        send(100, 1'b0, 4'hF, 0, first);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("midrst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("midrst_wr_push", {31'd0, wr_push}, 32'd0);
        chk("midrst_wr_data", wr_data, 32'd0);
        chk("midrst_wr_be", {28'd0, wr_be}, 32'd0);
        chk("midrst_pkt_count", {16'd0, pkt_count}, 32'd0);
        chk("midrst_timeout_count", {16'd0, timeout_count}, 32'd0);
        chk("midrst_queue_empty", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        p0 = push_cnt;
        repeat (100) @(negedge clk);
        #1;
        chk("midrst_no_push", push_cnt - p0, 0);
        send(2, 1'b1, 4'h3, 0, first);
        wait_push(p0 + 1, 200);
        repeat (2) @(negedge clk);
        #1;
        chk("postrst_pkt_count", {16'd0, pkt_count}, 32'd1);
        chk("postrst_last_be", {28'd0, last_be}, 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
